// File: rtl/nand_op_sequencer.sv
// -----------------------------------------------------------------------------
// nand_op_sequencer
//
// Breaks a high-level NAND operation (RESET, READ_PAGE, PROGRAM_PAGE,
// ERASE_BLOCK, READ_STATUS) into one or two controller transactions. Between
// steps it waits on the NAND ready/busy line. It reports completion with a
// one-cycle done pulse, an error flag and the last status byte read.
//
// Ports
//   clk, reset            clock (rising edge); synchronous active-high reset
//   op_valid/op_ready     operation handshake; op_ready is high only when idle
//   op_code[2:0]          0=RESET 1=READ_PAGE 2=PROGRAM_PAGE 3=ERASE_BLOCK
//                         4=READ_STATUS, 5-7 illegal
//   op_row/op_col/op_len  page row, column and data byte count
//   done, error, status   completion pulse, error (valid with done),
//                         last status byte
//   ctl_*                 one controller transaction per step:
//                         ctl_command = {cmd2,cmd1}, address, address byte
//                         count, data byte count, direction (1 = read),
//                         request/ready handshake, complete pulse
//   rb_n                  NAND ready/busy (already synchronised)
//   status_in             status byte, valid with ctl_complete
// -----------------------------------------------------------------------------
module nand_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TWB_CYCLES     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [23:0] op_row,
  input  logic [15:0] op_col,
  input  logic [11:0] op_len,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic [15:0] ctl_command,
  output logic        ctl_command_valid,
  output logic [31:0] ctl_address,
  output logic [3:0]  ctl_address_bytes,
  output logic [31:0] ctl_data_bytes,
  output logic        ctl_data_rw,
  output logic        ctl_request,
  input  logic        ctl_ready,
  input  logic        ctl_complete,
  input  logic        rb_n,
  input  logic [7:0]  status_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CPL,
    S_WAIT_RB_LOW,
    S_WAIT_RB_HIGH,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_RESET        = 3'd0;
  localparam logic [2:0] OP_READ_PAGE    = 3'd1;
  localparam logic [2:0] OP_PROGRAM_PAGE = 3'd2;
  localparam logic [2:0] OP_ERASE_BLOCK  = 3'd3;
  localparam logic [2:0] OP_READ_STATUS  = 3'd4;

  localparam logic [15:0] TWB_LIMIT     = 16'(TWB_CYCLES);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  // One controller transaction, plus what the sequencer does after it.
  typedef struct packed {
    logic [15:0] cmd;
    logic [31:0] addr;
    logic [3:0]  addr_bytes;
    logic [31:0] data_bytes;
    logic        rw;
    logic        rb_wait;    // wait for rb_n busy/ready after completion
    logic        is_status;  // capture status_in on completion
    logic        last;       // final step of the operation
  } step_t;

  localparam step_t STATUS_STEP = '{
    cmd:        16'h0070,
    addr:       32'h0,
    addr_bytes: 4'd0,
    data_bytes: 32'd1,
    rw:         1'b1,
    rb_wait:    1'b0,
    is_status:  1'b1,
    last:       1'b1
  };

  // Step table. Only rows below 2^16 are addressable in the 5-byte form, so
  // row[23:16] is dropped there. The 3-byte erase address carries the full row.
  function automatic step_t step_desc(input logic [2:0]  code,
                                      input logic [23:0] row,
                                      input logic [15:0] col,
                                      input logic [11:0] len,
                                      input logic        second);
    step_t s;
    s      = '0;
    s.last = 1'b1;
    case (code)
      OP_RESET: begin
        s.cmd     = 16'h00FF;
        s.rb_wait = 1'b1;
      end
      OP_READ_PAGE: begin
        if (!second) begin
          s.cmd        = 16'h3000;
          s.addr       = {row[15:0], col};
          s.addr_bytes = 4'd5;
          s.rb_wait    = 1'b1;
          s.last       = 1'b0;
        end else begin
          s.cmd        = 16'hE005;
          s.addr       = {16'h0, col};
          s.addr_bytes = 4'd2;
          s.data_bytes = {20'h0, len};
          s.rw         = 1'b1;
        end
      end
      OP_PROGRAM_PAGE: begin
        if (!second) begin
          s.cmd        = 16'h1080;
          s.addr       = {row[15:0], col};
          s.addr_bytes = 4'd5;
          s.data_bytes = {20'h0, len};
          s.rb_wait    = 1'b1;
          s.last       = 1'b0;
        end else begin
          s = STATUS_STEP;
        end
      end
      OP_ERASE_BLOCK: begin
        if (!second) begin
          s.cmd        = 16'hD060;
          s.addr       = {8'h0, row};
          s.addr_bytes = 4'd3;
          s.rb_wait    = 1'b1;
          s.last       = 1'b0;
        end else begin
          s = STATUS_STEP;
        end
      end
      OP_READ_STATUS: s = STATUS_STEP;
      default:        s = '0;
    endcase
    return s;
  endfunction

  state_t      state;
  step_t       cur;        // transaction currently presented / in flight
  logic [2:0]  code_q;
  logic [23:0] row_q;
  logic [15:0] col_q;
  logic [11:0] len_q;
  logic [15:0] cnt;

  step_t first_step;
  step_t next_step;
  logic  legal_op;
  logic  status_fail;

  assign first_step  = step_desc(op_code, op_row, op_col, op_len, 1'b0);
  assign next_step   = step_desc(code_q, row_q, col_q, len_q, 1'b1);
  assign legal_op    = (op_code <= OP_READ_STATUS);
  // A set pass/fail bit only counts as a failure for program and erase.
  assign status_fail = cur.is_status && status_in[0] &&
                       ((code_q == OP_PROGRAM_PAGE) || (code_q == OP_ERASE_BLOCK));

  assign ctl_command       = cur.cmd;
  assign ctl_address       = cur.addr;
  assign ctl_address_bytes = cur.addr_bytes;
  assign ctl_data_bytes    = cur.data_bytes;
  assign ctl_data_rw       = cur.rw;

  // NOTE: every register here uses non-blocking assignment so that all
  // branches see the pre-edge values of state, cur and cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      op_ready          <= 1'b1;
      done              <= 1'b0;
      error             <= 1'b0;
      status            <= 8'h00;
      ctl_request       <= 1'b0;
      ctl_command_valid <= 1'b0;
      cur               <= '0;
      code_q            <= 3'd0;
      row_q             <= 24'h0;
      col_q             <= 16'h0;
      len_q             <= 12'h0;
      cnt               <= 16'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            code_q   <= op_code;
            row_q    <= op_row;
            col_q    <= op_col;
            len_q    <= op_len;
            op_ready <= 1'b0;
            if (!legal_op) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              cur               <= first_step;
              ctl_request       <= 1'b1;
              ctl_command_valid <= 1'b1;
              state             <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (ctl_ready) begin
            ctl_request       <= 1'b0;
            ctl_command_valid <= 1'b0;
            state             <= S_WAIT_CPL;
          end
        end

        S_WAIT_CPL: begin
          if (ctl_complete) begin
            cnt <= 16'h0;
            if (cur.is_status) status <= status_in;
            if (cur.rb_wait) begin
              state <= S_WAIT_RB_LOW;
            end else if (cur.last) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= status_fail;
            end else begin
              cur               <= next_step;
              ctl_request       <= 1'b1;
              ctl_command_valid <= 1'b1;
              state             <= S_ISSUE;
            end
          end
        end

        // The part may never visibly go busy (short tWB); give up waiting
        // for the falling edge after TWB_CYCLES and go straight to the
        // ready wait.
        S_WAIT_RB_LOW: begin
          if (!rb_n || (cnt + 16'd1 >= TWB_LIMIT)) begin
            cnt   <= 16'h0;
            state <= S_WAIT_RB_HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_WAIT_RB_HIGH: begin
          if (rb_n) begin
            if (cur.last) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b0;
            end else begin
              cur               <= next_step;
              ctl_request       <= 1'b1;
              ctl_command_valid <= 1'b1;
              state             <= S_ISSUE;
            end
          end else if (cnt == TIMEOUT_LIMIT) begin
            // Timeout: abandon any remaining steps.
            state <= S_DONE;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_DONE: begin
          done     <= 1'b0;
          error    <= 1'b0;
          op_ready <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nand_op_sequencer
//
// Scoreboard bench. When the bench issues an op, it queues the expected
// controller transactions and the expected completion. A responder process
// models the controller and the NAND ready/busy line, and compares each
// transaction as it is requested. A monitor compares each done pulse against
// the result queue.
// -----------------------------------------------------------------------------
module tb_nand_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [23:0] op_row;
  logic [15:0] op_col;
  logic [11:0] op_len;
  logic        done;
  logic        error;
  logic [7:0]  status;
  logic [15:0] ctl_command;
  logic        ctl_command_valid;
  logic [31:0] ctl_address;
  logic [3:0]  ctl_address_bytes;
  logic [31:0] ctl_data_bytes;
  logic        ctl_data_rw;
  logic        ctl_request;
  logic        ctl_ready;
  logic        ctl_complete;
  logic        rb_n;
  logic [7:0]  status_in;

  nand_op_sequencer #(
    .TIMEOUT_CYCLES(100),
    .TWB_CYCLES    (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_code          (op_code),
    .op_row           (op_row),
    .op_col           (op_col),
    .op_len           (op_len),
    .done             (done),
    .error            (error),
    .status           (status),
    .ctl_command      (ctl_command),
    .ctl_command_valid(ctl_command_valid),
    .ctl_address      (ctl_address),
    .ctl_address_bytes(ctl_address_bytes),
    .ctl_data_bytes   (ctl_data_bytes),
    .ctl_data_rw      (ctl_data_rw),
    .ctl_request      (ctl_request),
    .ctl_ready        (ctl_ready),
    .ctl_complete     (ctl_complete),
    .rb_n             (rb_n),
    .status_in        (status_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [31:0] addr;
    logic [3:0]  ab;
    logic [31:0] db;
    logic        rw;
    logic        rb;
  } txn_t;

  typedef struct {
    logic       err;
    logic [7:0] st;
  } res_t;

  txn_t exp_txn[$];
  res_t exp_res[$];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc         = 0;
  int cpl_cyc     = 0;
  int done_cyc    = 0;
  int done_count  = 0;
  int hs_count    = 0;
  int req_cycles  = 0;
  logic done_prev = 1'b0;
  logic resp_busy = 1'b0;

  // Responder knobs, set by the main sequence before each op.
  int         ready_delay = 0;
  int         cpl_delay   = 2;
  logic [7:0] cpl_status  = 8'h00;
  int         rb_mode     = 0;   // 0: low for rb_low_len, 1: never falls, 2: stuck low
  int         rb_low_len  = 3;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor.
  res_t r;
  always @(negedge clk) begin
    if (ctl_request) req_cycles++;
    if (!reset && done) begin
      done_count++;
      done_cyc = cyc;
      check("done_single_cycle", 128'(done_prev), 128'(1'b0));
      if (exp_res.size() == 0) begin
        check("unexpected_done", 128'(1), 128'(0));
      end else begin
        r = exp_res.pop_front();
        check("error", 128'(error), 128'(r.err));
        check("status", 128'(status), 128'(r.st));
      end
    end
    done_prev = done;
  end

  // Controller + NAND model.
  initial begin : responder
    txn_t        t;
    logic [84:0] snap;
    int          dc0;
    ctl_ready    = 1'b0;
    ctl_complete = 1'b0;
    status_in    = 8'h00;
    rb_n         = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && ctl_request) begin
        resp_busy = 1'b1;
        snap = {ctl_command, ctl_address, ctl_address_bytes, ctl_data_bytes, ctl_data_rw};
        check("cmd_valid", 128'(ctl_command_valid), 128'(1'b1));
        if (exp_txn.size() == 0) begin
          check("unexpected_request", 128'(1), 128'(0));
          t = '{default: '0};
        end else begin
          t = exp_txn.pop_front();
          check("ctl_command", 128'(ctl_command), 128'(t.cmd));
          check("ctl_address", 128'(ctl_address), 128'(t.addr));
          check("ctl_address_bytes", 128'(ctl_address_bytes), 128'(t.ab));
          check("ctl_data_bytes", 128'(ctl_data_bytes), 128'(t.db));
          check("ctl_data_rw", 128'(ctl_data_rw), 128'(t.rw));
        end
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          check("request_hold",
                128'({ctl_request, ctl_command_valid, ctl_command, ctl_address,
                      ctl_address_bytes, ctl_data_bytes, ctl_data_rw}),
                128'({2'b11, snap}));
        end
        ctl_ready = 1'b1;
        @(negedge clk);
        ctl_ready = 1'b0;
        hs_count++;
        check("request_drop", 128'(ctl_request), 128'(1'b0));
        repeat (cpl_delay) @(negedge clk);
        ctl_complete = 1'b1;
        status_in    = cpl_status;
        @(negedge clk);
        ctl_complete = 1'b0;
        cpl_cyc      = cyc;
        if (t.rb) begin
          if (rb_mode == 0) begin
            rb_n = 1'b0;
            repeat (rb_low_len) @(negedge clk);
            rb_n = 1'b1;
          end else if (rb_mode == 2) begin
            rb_n = 1'b0;
            dc0  = done_count;
            for (int k = 0; k < 400; k++) begin
              @(negedge clk);
              if (done_count > dc0) break;
            end
            rb_n = 1'b1;
          end
        end
        resp_busy = 1'b0;
      end
    end
  end

  task automatic push_txn(input logic [15:0] cmd, input logic [31:0] addr,
                          input logic [3:0] ab, input logic [31:0] db,
                          input logic rw, input logic rb);
    txn_t t;
    t.cmd = cmd; t.addr = addr; t.ab = ab; t.db = db; t.rw = rw; t.rb = rb;
    exp_txn.push_back(t);
  endtask

  task automatic push_res(input logic err, input logic [7:0] st);
    res_t x;
    x.err = err;
    x.st  = st;
    exp_res.push_back(x);
  endtask

  // Returns at the negedge right after the accepting clock edge.
  task automatic issue_op(input logic [2:0] code, input logic [23:0] row,
                          input logic [15:0] col, input logic [11:0] len);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    check("op_ready_before_issue", 128'(op_ready), 128'(1'b1));
    op_valid = 1'b1;
    op_code  = code;
    op_row   = row;
    op_col   = col;
    op_len   = len;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_count;
    for (int k = 0; k < budget; k++) begin
      if (done_count > start) break;
      @(negedge clk);
    end
    check("done_seen", 128'(done_count - start), 128'(1));
  endtask

  task automatic finish_op();
    for (int k = 0; k < 500; k++) begin
      if (!resp_busy) break;
      @(negedge clk);
    end
    check("responder_idle", 128'(resp_busy), 128'(1'b0));
    repeat (2) @(negedge clk);
    check("txn_left", 128'(exp_txn.size()), 128'(0));
    check("res_left", 128'(exp_res.size()), 128'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int h0;
    int rq0;
    int dc0;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_row   = 24'h0;
    op_col   = 16'h0;
    op_len   = 12'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_op_ready", 128'(op_ready), 128'(1'b1));
    check("rst_done_error", 128'({done, error}), 128'(2'b00));
    check("rst_status", 128'(status), 128'(8'h00));
    check("rst_request", 128'({ctl_request, ctl_command_valid}), 128'(2'b00));
    check("rst_ctl_fields",
          128'({ctl_command, ctl_address, ctl_address_bytes, ctl_data_bytes, ctl_data_rw}),
          128'(0));
    reset = 1'b0;
    @(negedge clk);

    // READ_STATUS: status bit 0 set is not an error for this op
    cpl_status = 8'h01;
    push_txn(16'h0070, 32'h0, 4'd0, 32'd1, 1'b1, 1'b0);
    push_res(1'b0, 8'h01);
    issue_op(3'd4, 24'h0, 16'h0, 12'd0);
    wait_done(200);
    finish_op();

    // ERASE_BLOCK row 0x0123, busy 5 cycles, status 0xE0
    cpl_status = 8'hE0; rb_mode = 0; rb_low_len = 5;
    push_txn(16'hD060, 32'h0000_0123, 4'd3, 32'd0, 1'b0, 1'b1);
    push_txn(16'h0070, 32'h0, 4'd0, 32'd1, 1'b1, 1'b0);
    push_res(1'b0, 8'hE0);
    issue_op(3'd3, 24'h000123, 16'h0, 12'd0);
    wait_done(300);
    finish_op();

    // PROGRAM_PAGE len 2048, status 0xE1 -> error; row[23:16] dropped
    cpl_status = 8'hE1; rb_low_len = 4;
    push_txn(16'h1080, 32'h1234_0010, 4'd5, 32'd2048, 1'b0, 1'b1);
    push_txn(16'h0070, 32'h0, 4'd0, 32'd1, 1'b1, 1'b0);
    push_res(1'b1, 8'hE1);
    issue_op(3'd2, 24'hAB1234, 16'h0010, 12'd2048);
    wait_done(300);
    finish_op();

    // READ_PAGE normal: status holds from the previous status step
    cpl_status = 8'h77; rb_low_len = 3;
    push_txn(16'h3000, 32'h0456_0800, 4'd5, 32'd0, 1'b0, 1'b1);
    push_txn(16'hE005, 32'h0000_0800, 4'd2, 32'd100, 1'b1, 1'b0);
    push_res(1'b0, 8'hE1);
    issue_op(3'd1, 24'h000456, 16'h0800, 12'd100);
    wait_done(300);
    finish_op();

    // READ_PAGE with rb_n stuck low -> timeout, no second step
    rb_mode = 2;
    push_txn(16'h3000, 32'h0001_0002, 4'd5, 32'd0, 1'b0, 1'b1);
    push_res(1'b1, 8'hE1);
    issue_op(3'd1, 24'h000001, 16'h0002, 12'd16);
    wait_done(400);
    // 1 cycle in WAIT_RB_LOW + 101 cycles in WAIT_RB_HIGH
    check("timeout_latency", 128'(done_cyc - cpl_cyc), 128'(102));
    finish_op();

    // Illegal op_code 6: done one cycle after acceptance, no request
    rq0 = req_cycles;
    push_res(1'b1, 8'hE1);
    issue_op(3'd6, 24'h0, 16'h0, 12'd0);
    check("illegal_done_next_cycle", 128'({done, error}), 128'(2'b11));
    repeat (3) @(negedge clk);
    check("illegal_no_request", 128'(req_cycles - rq0), 128'(0));
    check("illegal_res_left", 128'(exp_res.size()), 128'(0));

    // RESET op with rb_n never falling: tWB bound of 8 cycles
    rb_mode = 1;
    push_txn(16'h00FF, 32'h0, 4'd0, 32'd0, 1'b0, 1'b1);
    push_res(1'b0, 8'hE1);
    issue_op(3'd0, 24'h0, 16'h0, 12'd0);
    wait_done(200);
    // 8 cycles in WAIT_RB_LOW + 1 cycle in WAIT_RB_HIGH
    check("twb_latency", 128'(done_cyc - cpl_cyc), 128'(9));
    finish_op();

    // ctl_ready held low 10 cycles, then reset while waiting for completion
    ready_delay = 10; cpl_delay = 20; cpl_status = 8'h5A; rb_mode = 0;
    push_txn(16'h0070, 32'h0, 4'd0, 32'd1, 1'b1, 1'b0);
    h0 = hs_count;
    issue_op(3'd4, 24'h0, 16'h0, 12'd0);
    for (int k = 0; k < 50; k++) begin
      if (hs_count > h0) break;
      @(negedge clk);
    end
    check("handshake_seen", 128'(hs_count - h0), 128'(1));
    repeat (2) @(negedge clk);
    dc0   = done_count;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_request", 128'({ctl_request, ctl_command_valid}), 128'(2'b00));
    check("midrst_op_ready", 128'(op_ready), 128'(1'b1));
    check("midrst_status", 128'(status), 128'(8'h00));
    @(negedge clk);
    reset = 1'b0;
    finish_op();
    check("midrst_no_done", 128'(done_count - dc0), 128'(0));
    check("stray_complete_ignored", 128'(status), 128'(8'h00));

    // Recovery after reset
    ready_delay = 0; cpl_delay = 2; cpl_status = 8'h33;
    push_txn(16'h0070, 32'h0, 4'd0, 32'd1, 1'b1, 1'b0);
    push_res(1'b0, 8'h33);
    issue_op(3'd4, 24'h0, 16'h0, 12'd0);
    wait_done(200);
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
